// File: rtl/simon_seq_engine.sv
// simon_seq_engine: Galois LFSR symbol source plus a sequence buffer.
// Random symbols are appended one per round. The stored sequence is replayed
// over a valid/ready stream. A combinational check port lets the player-compare
// logic read any stored symbol.
module simon_seq_engine #(
  parameter int                SYM_W      = 2,
  parameter int                MAX_LEN    = 32,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1,
  localparam int               LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen_en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              append,
  input  logic              clear,
  input  logic              replay_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [LEN_W-1:0]  out_idx,
  output logic              out_last,
  output logic              replay_done,
  output logic              busy,
  input  logic [LEN_W-1:0]  chk_idx,
  output logic [SYM_W-1:0]  chk_sym,
  output logic [LEN_W-1:0]  seq_len,
  output logic              full
);

  // The buffer spans the full index range so any LEN_W-bit index addresses it
  // directly; entries at or beyond MAX_LEN are never written or reported.
  localparam int DEPTH = 1 << LEN_W;

  typedef enum logic {S_IDLE, S_REPLAY} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [SYM_W-1:0]    mem_q [DEPTH];

  logic                full_w;
  logic                append_ok;
  logic                wr_en;
  logic [LEN_W-1:0]    idx_nxt;
  logic [LFSR_W-1:0]   lfsr_step;

  assign full_w    = (len_q == LEN_W'(MAX_LEN));
  assign append_ok = (state_q == S_IDLE) && append && !full_w && !clear;
  assign idx_nxt   = idx_q + LEN_W'(1);
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // Next-state logic for LFSR, sequence length and the replay FSM.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sym_d   = sym_q;
    vld_d   = vld_q;
    last_d  = last_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;

    // A zero seed would lock the LFSR up, so it is replaced by 1.
    if (seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    end else if (gen_en || append_ok) begin
      lfsr_d = lfsr_step;
    end

    if (clear) begin
      len_d   = '0;
      state_d = S_IDLE;
      vld_d   = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (append_ok) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
          end
          if (replay_start) begin
            if (len_q != '0) begin
              state_d = S_REPLAY;
              vld_d   = 1'b1;
              idx_d   = '0;
              sym_d   = mem_q[0];
              last_d  = (len_q == LEN_W'(1));
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_REPLAY: begin
          if (vld_q && out_ready) begin
            if (last_q) begin
              state_d = S_IDLE;
              vld_d   = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_nxt;
              sym_d  = mem_q[idx_nxt];
              last_d = (idx_nxt == (len_q - LEN_W'(1)));
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= RESET_SEED;
      len_q   <= '0;
      idx_q   <= '0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Symbol storage: written with the pre-edge LFSR value, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[len_q] <= lfsr_q[SYM_W-1:0];
    end
  end

  assign out_valid   = vld_q;
  assign out_sym     = sym_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;
  assign replay_done = done_q;
  assign busy        = (state_q == S_REPLAY);
  assign seq_len     = len_q;
  assign full        = full_w;
  assign chk_sym     = (chk_idx < len_q) ? mem_q[chk_idx] : '0;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Self-checking bench for simon_seq_engine with a behavioural sequence model.
module tb_simon_seq_engine;

  localparam int LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             gen_en = 1'b0;
  logic             seed_load = 1'b0;
  logic [15:0]      seed = '0;
  logic             append = 1'b0;
  logic             clear = 1'b0;
  logic             replay_start = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_sym;
  logic [LEN_W-1:0] out_idx;
  logic             out_last;
  logic             replay_done;
  logic             busy;
  logic [LEN_W-1:0] chk_idx = '0;
  logic [1:0]       chk_sym;
  logic [LEN_W-1:0] seq_len;
  logic             full;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the LFSR value, and the stored symbols as a queue.
  logic [15:0] m_lfsr;
  logic [1:0]  m_seq[$];

  simon_seq_engine dut (
    .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load), .seed(seed),
    .append(append), .clear(clear), .replay_start(replay_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_idx(out_idx), .out_last(out_last), .replay_done(replay_done),
    .busy(busy), .chk_idx(chk_idx), .chk_sym(chk_sym), .seq_len(seq_len),
    .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_append();
    append = 1'b1;
    tick();
    append = 1'b0;
    if (m_seq.size() < 32) begin
      m_seq.push_back(m_lfsr[1:0]);
      m_lfsr = m_next(m_lfsr);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_seq.delete();
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'h0001 : s;
  endtask

  task automatic gen_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      gen_en = 1'($urandom_range(0, 1));
      tick();
      if (gen_en) m_lfsr = m_next(m_lfsr);
    end
    gen_en = 1'b0;
  endtask

  // Compares the whole check port, including two indices past the end.
  task automatic compare_buffer(input string tag);
    for (int i = 0; i < 34; i++) begin
      logic [1:0] exp;
      chk_idx = LEN_W'(i);
      #1;
      exp = (i < m_seq.size()) ? m_seq[i] : 2'b00;
      checks++;
      if (chk_sym !== exp) begin
        errors++;
        $display("FAIL %s chk_sym[%0d] got %b expected %b", tag, i, chk_sym, exp);
      end
    end
    checks++;
    if (seq_len !== LEN_W'(m_seq.size())) begin
      errors++;
      $display("FAIL %s seq_len got %0d expected %0d", tag, seq_len, m_seq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    m_seq.delete();
    repeat (3) tick();
    checks++;
    if ({seq_len, full, out_valid, busy, replay_done, out_last, out_sym, out_idx} !== '0) begin
      errors++;
      $display("FAIL reset_state len=%0d full=%b vld=%b busy=%b done=%b last=%b sym=%b idx=%0d expected all 0",
               seq_len, full, out_valid, busy, replay_done, out_last, out_sym, out_idx);
    end
    do_append();
    chk_idx = '0;
    #1;
    checks++;
    if (chk_sym !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_sym got %b expected 01", chk_sym);
    end
  endtask

  task automatic test_zero_seed();
    logic [1:0] ref_syms [3];
    ref_syms[0] = 2'b01; ref_syms[1] = 2'b00; ref_syms[2] = 2'b00;
    for (int pass = 0; pass < 2; pass++) begin
      do_clear();
      do_seed(pass == 0 ? 16'h0000 : 16'h0001);
      repeat (3) do_append();
      for (int i = 0; i < 3; i++) begin
        chk_idx = LEN_W'(i);
        #1;
        checks++;
        if (chk_sym !== ref_syms[i]) begin
          errors++;
          $display("FAIL zero_seed pass%0d sym[%0d] got %b expected %b", pass, i, chk_sym, ref_syms[i]);
        end
      end
    end
    compare_buffer("zero_seed_model");
  endtask

  task automatic test_fill();
    do_clear();
    do_seed(16'($urandom_range(1, 16'hFFFF)));
    for (int i = 1; i <= 33; i++) begin
      do_append();
      checks++;
      if (full !== (i >= 32)) begin
        errors++;
        $display("FAIL fill_full after %0d appends got %b expected %b", i, full, (i >= 32));
      end
    end
    compare_buffer("fill");
    // The ignored append must not have stepped the LFSR.
    do_clear();
    repeat (6) do_append();
    compare_buffer("fill_no_step");
  endtask

  task automatic test_replay();
    int exp_idx;
    int dones;
    bit finished;
    bit hs, was_last;
    do_clear();
    do_seed(16'($urandom_range(1, 16'hFFFF)));
    for (int i = 0; i < 5; i++) begin
      gen_cycles(3);
      do_append();
    end
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    exp_idx = 0;
    dones = 0;
    finished = 0;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      chk_idx = out_idx;
      #1;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== LEN_W'(exp_idx) ||
          out_sym !== m_seq[exp_idx] || out_last !== (exp_idx == 4) || chk_sym !== out_sym) begin
        errors++;
        $display("FAIL replay_beat vld=%b busy=%b idx=%0d sym=%b last=%b chk=%b expected idx=%0d sym=%b last=%b",
                 out_valid, busy, out_idx, out_sym, out_last, chk_sym, exp_idx, m_seq[exp_idx], (exp_idx == 4));
      end
      out_ready = cyc[0];
      append = 1'b1;
      hs = out_valid && out_ready;
      was_last = out_last;
      tick();
      append = 1'b0;
      if (replay_done) dones++;
      if (hs && was_last) finished = 1;
      else if (hs) exp_idx++;
    end
    out_ready = 1'b0;
    checks++;
    if (!finished || out_valid !== 1'b0 || replay_done !== 1'b1) begin
      errors++;
      $display("FAIL replay_end finished=%0d vld=%b done=%b expected 1 0 1", finished, out_valid, replay_done);
    end
    tick();
    if (replay_done) dones++;
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL replay_done_count got %0d busy=%b expected 1 busy=0", dones, busy);
    end
    compare_buffer("replay_no_append");
  endtask

  task automatic test_clear_mid();
    int guard;
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (out_idx != LEN_W'(2) && guard < 10) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_idx !== LEN_W'(2) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_reach_idx2 idx=%0d vld=%b expected 2 1", out_idx, out_valid);
    end
    do_clear();
    checks++;
    if (out_valid !== 1'b0 || seq_len !== '0 || busy !== 1'b0 || replay_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid vld=%b len=%0d busy=%b done=%b expected 0 0 0 0", out_valid, seq_len, busy, replay_done);
    end
    tick();
    checks++;
    if (replay_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_done got %b expected 0", replay_done);
    end
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    checks++;
    if (replay_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_replay done=%b vld=%b busy=%b expected 1 0 0", replay_done, out_valid, busy);
    end
    tick();
    checks++;
    if (replay_done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_replay_pulse done=%b vld=%b expected 0 0", replay_done, out_valid);
    end
  endtask

  task automatic test_async_reset();
    repeat (5) do_append();
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, replay_done, out_last, out_sym, out_idx, seq_len, full} !== '0) begin
      errors++;
      $display("FAIL async_reset vld=%b busy=%b done=%b last=%b sym=%b idx=%0d len=%0d full=%b expected all 0",
               out_valid, busy, replay_done, out_last, out_sym, out_idx, seq_len, full);
    end
    #1;
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    m_seq.delete();
    tick();
    checks++;
    if (replay_done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after done=%b vld=%b expected 0 0", replay_done, out_valid);
    end
  endtask

  task automatic test_append_seed();
    logic [15:0] s;
    s = 16'($urandom_range(1, 16'hFFFF));
    seed = s;
    seed_load = 1'b1;
    append = 1'b1;
    tick();
    seed_load = 1'b0;
    append = 1'b0;
    m_seq.push_back(m_lfsr[1:0]);
    m_lfsr = s;
    chk_idx = '0;
    #1;
    checks++;
    if (chk_sym !== 2'b01) begin
      errors++;
      $display("FAIL append_seed_old got %b expected 01", chk_sym);
    end
    repeat (8) do_append();
    compare_buffer("append_seed_new");
  endtask

  initial begin
    test_reset();
    test_zero_seed();
    test_fill();
    test_replay();
    test_clear_mid();
    test_async_reset();
    test_append_seed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
